dma_copy: RTL

Memory-to-memory word copy engine for the simple system bus. It attaches to the bus twice: as a device, for its configuration registers, and as an additional host, which issues read/write transfers on the bus. Software programs source, destination and length, then starts the copy. The engine moves the data one word at a time and raises a level interrupt when the copy completes.

---
 rtl/dma_copy.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_copy.sv
// dma_copy: memory-to-memory word copy engine with a register device port and a bus host port.
// Optional fill mode (write PATTERN to LEN words instead of copying) is built when DMA_COPY_FILL_EN
// is defined.
module dma_copy #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    host_req_o,
  input  logic                    host_gnt_i,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [DataWidth-1:0]    host_wdata_o,
  input  logic                    host_rvalid_i,
  input  logic [DataWidth-1:0]    host_rdata_i,
  input  logic                    host_err_i,
  output logic                    dma_intr_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdReq  = 3'd1;
  localparam logic [2:0] StRdWait = 3'd2;
  localparam logic [2:0] StWrReq  = 3'd3;
  localparam logic [2:0] StWrWait = 3'd4;

  localparam logic [2:0] OffSrc     = 3'd0;
  localparam logic [2:0] OffDst     = 3'd1;
  localparam logic [2:0] OffLen     = 3'd2;
  localparam logic [2:0] OffCtrl    = 3'd3;
  localparam logic [2:0] OffStatus  = 3'd4;
  localparam logic [2:0] OffPattern = 3'd5;

`ifdef DMA_COPY_FILL_EN
  localparam bit FillEn = 1'b1;
`else
  localparam bit FillEn = 1'b0;
`endif

  logic [2:0]              state_q, state_d;
  logic [AddressWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [AddressWidth-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [LenWidth-1:0]     len_q, len_d, cnt_q, cnt_d;
  logic [DataWidth-1:0]    buf_q, buf_d;
  logic                    irq_en_q, irq_en_d;
  logic                    done_q, done_d, err_q, err_d;
  logic                    dev_rvalid_q;
  logic [DataWidth-1:0]    dev_rdata_q, dev_rdata_d;
  logic                    dev_err_q, dev_err_d;

  logic                    fill_cfg, fill_start;
  logic [DataWidth-1:0]    pattern_val;
  logic [DataWidth-1:0]    rd_mux;
  logic [2:0]              reg_off;
  logic                    reg_wr, reg_rd, ctrl_wr, status_wr, off_ok, busy;
  logic                    start_req, start_go, start_zero;
  logic                    fin_set, err_set;

  assign reg_off   = dev_addr_i[4:2];
  assign reg_wr    = dev_req_i & dev_we_i;
  assign reg_rd    = dev_req_i & ~dev_we_i;
  assign ctrl_wr   = reg_wr & (reg_off == OffCtrl);
  assign status_wr = reg_wr & (reg_off == OffStatus);
  assign busy      = (state_q != StIdle);

  // start is only honoured from IDLE; LEN is sampled as it stands before this write
  assign start_req  = ctrl_wr & dev_wdata_i[0] & ~busy;
  assign start_go   = start_req & (len_q != '0);
  assign start_zero = start_req & (len_q == '0);

  logic unused_dev;
  assign unused_dev = ^{dev_be_i, dev_addr_i[AddressWidth-1:5], dev_addr_i[1:0]};

`ifdef DMA_COPY_FILL_EN
  logic                 fill_q, fill_d;
  logic [DataWidth-1:0] pattern_q, pattern_d;

  always_comb begin
    fill_d    = fill_q;
    pattern_d = pattern_q;
    if (ctrl_wr && !busy) begin
      fill_d = dev_wdata_i[2];
    end
    if (reg_wr && (reg_off == OffPattern)) begin
      pattern_d = dev_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fill_q    <= 1'b0;
      pattern_q <= '0;
    end else begin
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
    end
  end

  assign fill_cfg    = fill_q;
  assign fill_start  = fill_d;
  assign pattern_val = pattern_q;
`else
  assign fill_cfg    = 1'b0;
  assign fill_start  = 1'b0;
  assign pattern_val = '0;
`endif

  // Register decode and read mux
  always_comb begin
    off_ok = 1'b1;
    rd_mux = '0;
    unique case (reg_off)
      OffSrc:     rd_mux = DataWidth'(src_q);
      OffDst:     rd_mux = DataWidth'(dst_q);
      OffLen:     rd_mux = DataWidth'(len_q);
      OffCtrl:    rd_mux = DataWidth'({fill_cfg, irq_en_q, 1'b0});
      OffStatus:  rd_mux = DataWidth'({err_q, done_q, busy});
      OffPattern: begin
        off_ok = FillEn;
        rd_mux = pattern_val;
      end
      default:    off_ok = 1'b0;
    endcase
  end

  always_comb begin
    dev_err_d   = dev_req_i & ~off_ok;
    dev_rdata_d = (reg_rd && off_ok) ? rd_mux : '0;
  end

  // Configuration registers; SRC/DST/LEN are frozen while a copy runs
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    if (reg_wr && !busy) begin
      if (reg_off == OffSrc) src_d = AddressWidth'(dev_wdata_i) & ~AddressWidth'(3);
      if (reg_off == OffDst) dst_d = AddressWidth'(dev_wdata_i) & ~AddressWidth'(3);
      if (reg_off == OffLen) len_d = dev_wdata_i[LenWidth-1:0];
    end
    if (ctrl_wr) begin
      irq_en_d = dev_wdata_i[1];
    end
  end

  // Copy engine
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    fin_set   = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_go) begin
          src_ptr_d = src_q;
          dst_ptr_d = dst_q;
          cnt_d     = len_q;
          if (fill_start) begin
            buf_d   = pattern_val;
            state_d = StWrReq;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        if (host_gnt_i) state_d = StRdWait;
      end
      StRdWait: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            fin_set = 1'b1;
            err_set = 1'b1;
            state_d = StIdle;
          end else begin
            buf_d   = host_rdata_i;
            state_d = StWrReq;
          end
        end
      end
      StWrReq: begin
        if (host_gnt_i) state_d = StWrWait;
      end
      StWrWait: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            fin_set = 1'b1;
            err_set = 1'b1;
            state_d = StIdle;
          end else begin
            src_ptr_d = src_ptr_q + AddressWidth'(4);
            dst_ptr_d = dst_ptr_q + AddressWidth'(4);
            cnt_d     = cnt_q - LenWidth'(1);
            if (cnt_q == LenWidth'(1)) begin
              fin_set = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = fill_cfg ? StWrReq : StRdReq;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky status: completion events win over a same-cycle W1C
  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    if (status_wr) begin
      if (dev_wdata_i[1]) done_d = 1'b0;
      if (dev_wdata_i[2]) err_d = 1'b0;
    end
    if (start_go) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (start_zero || fin_set) done_d = 1'b1;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      dev_rvalid_q <= 1'b0;
      dev_rdata_q  <= '0;
      dev_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      err_q        <= err_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      dev_rvalid_q <= dev_req_i;
      dev_rdata_q  <= dev_rdata_d;
      dev_err_q    <= dev_err_d;
    end
  end

  assign dev_rvalid_o = dev_rvalid_q;
  assign dev_rdata_o  = dev_rdata_q;
  assign dev_err_o    = dev_err_q;

  // Request is gated by reset so it drops in the same cycle reset is applied
  assign host_req_o   = rst_ni & ((state_q == StRdReq) | (state_q == StWrReq));
  assign host_we_o    = (state_q == StWrReq);
  assign host_addr_o  = (state_q == StRdReq) ? src_ptr_q : dst_ptr_q;
  assign host_be_o    = 4'hF;
  assign host_wdata_o = buf_q;
  assign dma_intr_o   = done_q & irq_en_q;

endmodule
